// File: rtl/time_tag_decoder_if.sv
// time_tag_decoder_if: word stream, tag outputs and counter bus between link and backend
interface time_tag_decoder_if #(parameter int SAT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             tag_valid;
  logic [3:0]       tag_module;
  logic [47:0]      tag_period;
  logic             tag_seq_err;
  logic [47:0]      ref_period;
  logic             clear_counts;
  logic [SAT_W-1:0] frame_err_cnt;
  logic [SAT_W-1:0] seq_err_cnt;
  modport master (
    output in_valid, in_data, out_ready, clear_counts,
    input  in_ready, out_valid, out_data, tag_valid, tag_module, tag_period,
           tag_seq_err, ref_period, frame_err_cnt, seq_err_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready, clear_counts,
    output in_ready, out_valid, out_data, tag_valid, tag_module, tag_period,
           tag_seq_err, ref_period, frame_err_cnt, seq_err_cnt
  );
endinterface

// File: rtl/time_tag_decoder.sv
// time_tag_decoder: validates framing, decodes time tags with per-module sequence tracking, forwards other words
module time_tag_decoder #(
  parameter int         SAT_W      = 16,
  parameter logic [3:0] REF_MODULE = 4'd0
) (
  input logic               clk,
  input logic               rst,
  time_tag_decoder_if.slave bus
);
  logic             in_ready;
  logic             accept;
  logic             frame_ok;
  logic             tag_fmt;
  logic             pad_zero;
  logic             is_tag;
  logic             is_bad;
  logic             is_fwd;
  logic [3:0]       mod;
  logic [47:0]      per;
  logic             seq_bad;
  logic [47:0]      last_q [16];
  logic [15:0]      seen_q;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             tag_valid_q;
  logic [3:0]       tag_module_q;
  logic [47:0]      tag_period_q;
  logic             tag_seq_err_q;
  logic [47:0]      ref_period_q;
  logic [SAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SAT_W-1:0] seq_cnt_q, seq_cnt_d;

  // Classify the accepted word and compute next state of the out stage and counters
  always_comb begin
    in_ready    = rst & (~out_valid_q | bus.out_ready);
    accept      = bus.in_valid & in_ready;
    frame_ok    = bus.in_data[127:123] == 5'h1f;
    tag_fmt     = ~bus.in_data[122] & ~bus.in_data[115];
    pad_zero    = bus.in_data[114:48] == 67'd0;
    mod         = bus.in_data[121:118];
    per         = bus.in_data[47:0];
    is_tag      = accept & frame_ok & tag_fmt & pad_zero;
    is_bad      = accept & (~frame_ok | (tag_fmt & ~pad_zero));
    is_fwd      = accept & frame_ok & ~tag_fmt;
    seq_bad     = seen_q[mod] & (per != last_q[mod] + 48'd1);
    out_valid_d = is_fwd ? 1'b1 : (out_valid_q & bus.out_ready) ? 1'b0 : out_valid_q;
    out_data_d  = is_fwd ? bus.in_data : out_data_q;
    frame_cnt_d = bus.clear_counts ? '0 : (is_bad & ~&frame_cnt_q) ? frame_cnt_q + SAT_W'(1) : frame_cnt_q;
    seq_cnt_d   = bus.clear_counts ? '0 : (is_tag & seq_bad & ~&seq_cnt_q) ? seq_cnt_q + SAT_W'(1) : seq_cnt_q;
  end

  // Out stage, tag outputs, seen flags, reference period and error counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      tag_valid_q   <= 1'b0;
      tag_module_q  <= '0;
      tag_period_q  <= '0;
      tag_seq_err_q <= 1'b0;
      ref_period_q  <= '0;
      frame_cnt_q   <= '0;
      seq_cnt_q     <= '0;
      seen_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tag_valid_q <= is_tag;
      frame_cnt_q <= frame_cnt_d;
      seq_cnt_q   <= seq_cnt_d;
      if (is_tag) begin
        tag_module_q  <= mod;
        tag_period_q  <= per;
        tag_seq_err_q <= seq_bad;
        seen_q[mod]   <= 1'b1;
        if (mod == REF_MODULE) ref_period_q <= per;
      end
    end
  end

  // Last period per module; only meaningful where the matching seen flag is set
  always_ff @(posedge clk) begin
    if (rst && is_tag) last_q[mod] <= per;
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.tag_valid     = tag_valid_q;
  assign bus.tag_module    = tag_module_q;
  assign bus.tag_period    = tag_period_q;
  assign bus.tag_seq_err   = tag_seq_err_q;
  assign bus.ref_period    = ref_period_q;
  assign bus.frame_err_cnt = frame_cnt_q;
  assign bus.seq_err_cnt   = seq_cnt_q;
endmodule

// File: tb/tb_time_tag_decoder.sv
// tb_time_tag_decoder: randomized scoreboard bench for time_tag_decoder
module tb_time_tag_decoder;
  localparam int SW   = 8;
  localparam int MAXC = (1 << SW) - 1;

  typedef struct {
    logic [3:0]  m;
    logic [47:0] p;
    logic        e;
  } tag_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  time_tag_decoder_if #(.SAT_W(SW)) bus();
  time_tag_decoder #(.SAT_W(SW), .REF_MODULE(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks   = 0;
  int          failures = 0;
  int          or_mode  = 0;
  int          tag_seen = 0;
  tag_t        tagq[$];
  logic [127:0] fwdq[$];
  logic [47:0] last_m [16];
  bit          seen_m [16];
  int          frame_m = 0;
  int          seq_m   = 0;
  logic [47:0] ref_m   = '0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic int sat(input int x);
    return (x < MAXC) ? x + 1 : x;
  endfunction

  function automatic logic [127:0] tag_w(input logic [3:0] m, input logic [47:0] p);
    return {5'h1f, 1'b0, m, 2'b00, 1'b0, 67'd0, p};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] single_w();
    logic [127:0] w = rnd128();
    w[127:123] = 5'h1f;
    w[122]     = 1'b1;
    return w;
  endfunction

  function automatic logic [127:0] cmd_w();
    logic [127:0] w = rnd128();
    w[127:123] = 5'h1f;
    w[122]     = 1'b0;
    w[115]     = 1'b1;
    return w;
  endfunction

  function automatic logic [127:0] badframe_w();
    logic [127:0] w = rnd128();
    w[127:123] = 5'($urandom_range(0, 30));
    return w;
  endfunction

  function automatic logic [127:0] badpad_w();
    logic [127:0] w = tag_w(4'($urandom_range(0, 15)), 48'({$urandom, $urandom}));
    w[60] = 1'b1;
    return w;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) seen_m[i] = 1'b0;
    frame_m = 0;
    seq_m   = 0;
    ref_m   = '0;
    tagq.delete();
    fwdq.delete();
  endfunction

  // Reference behaviour of one accepted word
  function automatic void model(input logic [127:0] w, input logic clr);
    tag_t   t;
    longint nxt;
    if (w[127:123] != 5'h1f) frame_m = sat(frame_m);
    else if (w[122] || w[115]) fwdq.push_back(w);
    else if (w[114:48] != 67'd0) frame_m = sat(frame_m);
    else begin
      t.m = w[121:118];
      t.p = w[47:0];
      nxt = (longint'(last_m[t.m]) + 1) % (longint'(1) << 48);
      t.e = seen_m[t.m] && (longint'(t.p) != nxt);
      if (t.e) seq_m = sat(seq_m);
      last_m[t.m] = t.p;
      seen_m[t.m] = 1'b1;
      if (t.m == 4'd0) ref_m = t.p;
      tagq.push_back(t);
    end
    if (clr) begin
      frame_m = 0;
      seq_m   = 0;
    end
  endfunction

  task automatic send(input logic [127:0] w, input logic clr);
    int   n = 0;
    logic acc;
    bus.in_valid     = 1'b1;
    bus.in_data      = w;
    bus.clear_counts = clr;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      n++;
      if (acc) model(w, clr);
      @(posedge clk);
      #1;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=in_ready_low exp=accept_within_200");
    end
    bus.in_valid     = 1'b0;
    bus.clear_counts = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    or_mode       = m;
    bus.out_ready = (m != 2);
  endtask

  // Downstream ready pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pop and compare whenever the DUT presents a word or a tag
  initial begin
    tag_t t;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.out_valid && bus.out_ready) begin
          if (fwdq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fwd_unexpected got=%0h exp=none", bus.out_data);
          end else chk("fwd_data", bus.out_data, fwdq.pop_front());
        end
        if (bus.tag_valid) begin
          tag_seen++;
          if (tagq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tag_unexpected got=%0h exp=none", bus.tag_period);
          end else begin
            t = tagq.pop_front();
            chk("tag_module", 128'(bus.tag_module), 128'(t.m));
            chk("tag_period", 128'(bus.tag_period), 128'(t.p));
            chk("tag_seq_err", 128'(bus.tag_seq_err), 128'(t.e));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a;
    int           ts;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.clear_counts = 1'b0;
    model_reset();
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_tag_valid", 128'(bus.tag_valid), 128'(0));
    chk("rst_tag_module", 128'(bus.tag_module), 128'(0));
    chk("rst_tag_period", 128'(bus.tag_period), 128'(0));
    chk("rst_tag_seq_err", 128'(bus.tag_seq_err), 128'(0));
    chk("rst_ref_period", 128'(bus.ref_period), 128'(0));
    chk("rst_frame_cnt", 128'(bus.frame_err_cnt), 128'(0));
    chk("rst_seq_cnt", 128'(bus.seq_err_cnt), 128'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    ts = tag_seen;
    send(tag_w(4'd3, 48'd5), 1'b0);
    send(tag_w(4'd3, 48'd6), 1'b0);
    send(tag_w(4'd3, 48'd7), 1'b0);
    idle(2);
    chk("t1_pulses", 128'(tag_seen - ts), 128'(3));
    chk("t1_seq_cnt", 128'(bus.seq_err_cnt), 128'(0));
    chk("t1_tag_period", 128'(bus.tag_period), 128'(7));

    send(tag_w(4'd9, 48'd10), 1'b0);
    send(tag_w(4'd9, 48'd12), 1'b0);
    send(tag_w(4'd9, 48'd12), 1'b0);
    idle(2);
    chk("t2_seq_cnt", 128'(bus.seq_err_cnt), 128'(2));
    chk("t2_seq_err_held", 128'(bus.tag_seq_err), 128'(1));

    send(tag_w(4'd0, 48'hFFFF_FFFF_FFFF), 1'b0);
    idle(1);
    chk("t3_ref_max", 128'(bus.ref_period), 128'(48'hFFFF_FFFF_FFFF));
    send(tag_w(4'd0, 48'd0), 1'b0);
    idle(2);
    chk("t3_ref_zero", 128'(bus.ref_period), 128'(0));
    chk("t3_wrap_ok", 128'(bus.tag_seq_err), 128'(0));
    chk("t3_seq_cnt", 128'(bus.seq_err_cnt), 128'(2));

    a = tag_w(4'd2, 48'd100);
    a[127:123] = 5'b11110;
    send(a, 1'b0);
    a = tag_w(4'd2, 48'd100);
    a[60] = 1'b1;
    send(a, 1'b0);
    idle(2);
    chk("t4_frame_cnt", 128'(bus.frame_err_cnt), 128'(2));
    chk("t4_no_out", 128'(bus.out_valid), 128'(0));

    set_mode(2);
    a = single_w();
    send(a, 1'b0);
    fork
      send(single_w(), 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t5_hold_valid", 128'(bus.out_valid), 128'(1));
          chk("t5_hold_data", bus.out_data, a);
          chk("t5_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk);
        #1 set_mode(0);
      end
    join
    set_mode(1);
    for (int i = 0; i < 20; i++) begin
      send(single_w(), 1'b0);
      send(tag_w(4'd3, 48'(8 + i)), 1'b0);
    end
    set_mode(0);
    idle(3);
    chk("t5_seq_cnt", 128'(bus.seq_err_cnt), 128'(seq_m));

    set_mode(2);
    send(single_w(), 1'b0);
    idle(1);
    rst = 1'b0;
    model_reset();
    idle(2);
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    set_mode(0);
    idle(2);
    chk("mid_rst_after_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_ref", 128'(bus.ref_period), 128'(0));
    chk("mid_rst_seq_cnt", 128'(bus.seq_err_cnt), 128'(0));

    set_mode(1);
    for (int i = 0; i < 1500; i++) begin
      int          r = $urandom_range(0, 9);
      logic [3:0]  m = 4'($urandom_range(0, 3));
      logic [47:0] p;
      case (r)
        0, 1, 2, 3, 4: begin
          p = ($urandom_range(0, 3) != 0) ? last_m[m] + 48'd1 : ($urandom_range(0, 1) != 0) ? last_m[m] : 48'({$urandom, $urandom});
          if (!seen_m[m]) p = 48'({$urandom, $urandom});
          send(tag_w(m, p), 1'b0);
        end
        5, 6: send(single_w(), 1'b0);
        7: send(cmd_w(), 1'b0);
        8: send(badframe_w(), 1'b0);
        default: send(badpad_w(), 1'b0);
      endcase
    end
    set_mode(0);
    idle(3);
    chk("rnd_frame_cnt", 128'(bus.frame_err_cnt), 128'(frame_m));
    chk("rnd_seq_cnt", 128'(bus.seq_err_cnt), 128'(seq_m));
    chk("rnd_ref", 128'(bus.ref_period), 128'(ref_m));

    send(tag_w(4'd7, 48'd0), 1'b1);
    idle(1);
    chk("sat_cleared", 128'(bus.seq_err_cnt), 128'(0));
    for (int i = 0; i < 300; i++) send(tag_w(4'd7, 48'd0), 1'b0);
    idle(2);
    chk("sat_max", 128'(bus.seq_err_cnt), 128'(MAXC));
    send(tag_w(4'd7, 48'd0), 1'b1);
    idle(2);
    chk("clr_wins", 128'(bus.seq_err_cnt), 128'(0));
    chk("clr_frame", 128'(bus.frame_err_cnt), 128'(0));
    chk("clr_tag_err", 128'(bus.tag_seq_err), 128'(1));

    idle(5);
    chk("drain_fwdq", 128'(fwdq.size()), 128'(0));
    chk("drain_tagq", 128'(tagq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
